// File: rtl/regfile_dump.sv
// Read-side sequencer that walks the register file two registers at a time and
// streams every register out as an {index, data} beat over valid/ready.
module regfile_dump #(
    parameter int N    = 64,
    parameter int NREG = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic [4:0]   ra1,
    output logic [4:0]   ra2,
    input  logic [N-1:0] rd1,
    input  logic [N-1:0] rd2,
    input  logic         we3,
    input  logic [4:0]   wa3,
    output logic         dump_valid,
    input  logic         dump_ready,
    output logic [4:0]   dump_idx,
    output logic [N-1:0] dump_data,
    output logic         busy,
    output logic         done
);

    localparam int KW = (NREG > 2) ? $clog2(NREG / 2) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NREG / 2 - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_READ   = 3'd1;
    localparam logic [2:0] S_SEND_A = 3'd2;
    localparam logic [2:0] S_SEND_B = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [4:0]    ra1_q, ra1_d;
    logic [4:0]    ra2_q, ra2_d;
    logic [N-1:0]  buf_b_q, buf_b_d;
    logic          dump_valid_q, dump_valid_d;
    logic [4:0]    dump_idx_q, dump_idx_d;
    logic [N-1:0]  dump_data_q, dump_data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          hazard;
    logic [KW-1:0] k_nxt;

    // A write landing on the pair being read this edge would make the capture
    // stale, so READ waits one cycle and samples the updated value.
    assign hazard = we3 && (wa3 != 5'd31) && ((wa3 == ra1_q) || (wa3 == ra2_q));
    assign k_nxt  = k_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        ra1_d        = ra1_q;
        ra2_d        = ra2_q;
        buf_b_d      = buf_b_q;
        dump_valid_d = dump_valid_q;
        dump_idx_d   = dump_idx_q;
        dump_data_d  = dump_data_q;
        busy_d       = busy_q;
        done_d       = done_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ra1_d   = 5'd0;
                    ra2_d   = 5'd1;
                    k_d     = '0;
                    busy_d  = 1'b1;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (!hazard) begin
                    buf_b_d      = rd2;
                    dump_valid_d = 1'b1;
                    dump_idx_d   = ra1_q;
                    dump_data_d  = rd1;
                    state_d      = S_SEND_A;
                end
            end
            S_SEND_A: begin
                if (dump_valid_q && dump_ready) begin
                    dump_idx_d  = ra2_q;
                    dump_data_d = buf_b_q;
                    state_d     = S_SEND_B;
                end
            end
            S_SEND_B: begin
                if (dump_valid_q && dump_ready) begin
                    dump_valid_d = 1'b0;
                    if (k_q == K_LAST) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        k_d     = k_nxt;
                        ra1_d   = 5'({k_nxt, 1'b0});
                        ra2_d   = 5'({k_nxt, 1'b1});
                        state_d = S_READ;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d      = S_IDLE;
                dump_valid_d = 1'b0;
                busy_d       = 1'b0;
                done_d       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            k_q          <= '0;
            ra1_q        <= 5'd0;
            ra2_q        <= 5'd1;
            buf_b_q      <= '0;
            dump_valid_q <= 1'b0;
            dump_idx_q   <= 5'd0;
            dump_data_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            ra1_q        <= ra1_d;
            ra2_q        <= ra2_d;
            buf_b_q      <= buf_b_d;
            dump_valid_q <= dump_valid_d;
            dump_idx_q   <= dump_idx_d;
            dump_data_q  <= dump_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign ra1        = ra1_q;
    assign ra2        = ra2_q;
    assign dump_valid = dump_valid_q;
    assign dump_idx   = dump_idx_q;
    assign dump_data  = dump_data_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
- Read-side sequencer for the 32 x 64-bit LEGv8 register file (`regfile`).
- On a start pulse, drives the two combinational read ports (`ra1`/`ra2`) in register pairs and captures `rd1`/`rd2`.
- Streams every register out as an {index, data} beat over a valid/ready interface.
- Used for debug readout of architectural state after program execution. It monitors the writeback port (`we3`/`wa3`) so that captured values are never stale.

Parameters:
- N, 64, data width of a register.
- NREG, 32, number of registers. Must be even; indices 0..NREG-1.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a dump; ignored while busy=1.
- ra1  out  5  regfile read address 1 (even register of current pair).
- ra2  out  5  regfile read address 2 (odd register of current pair).
- rd1  in  N  regfile read data 1 (combinational from ra1).
- rd2  in  N  regfile read data 2 (combinational from ra2).
- we3  in  1  writeback write enable, monitored only.
- wa3  in  5  writeback write address, monitored only.
- dump_valid  out  1  beat valid.
- dump_ready  in  1  consumer ready.
- dump_idx  out  5  register index of current beat.
- dump_data  out  N  register value of current beat.
- busy  out  1  high from the cycle after start is accepted until DONE is left.
- done  out  1  one-cycle pulse when the final beat has been accepted.

Behaviour:
- All outputs are registered.
- Reset values: ra1=0, ra2=1, dump_valid=0, dump_idx=0, dump_data=0, busy=0, done=0. State=IDLE, pair counter k=0.
- Reset has priority over every other event, including mid-dump and mid-handshake.
- IDLE: busy=0, dump_valid=0. If start=1 at a posedge: ra1<=0, ra2<=1, k<=0, busy<=1, go to READ.
- READ (ra1=2k, ra2=2k+1 stable):
  - Hazard condition: we3=1 and wa3!=31 and (wa3==ra1 or wa3==ra2).
  - If hazard: stay in READ (the write lands this edge; values are re-read next cycle).
  - Otherwise: bufA<=rd1, bufB<=rd2, dump_valid<=1, dump_idx<=ra1, dump_data<=rd1, go to SEND_A.
- SEND_A: hold dump_idx/dump_data stable while dump_valid=1 and dump_ready=0. On dump_valid and dump_ready: dump_idx<=ra2, dump_data<=bufB, go to SEND_B (dump_valid stays 1).
- SEND_B: hold stable while not ready. On handshake:
  - If k==NREG/2-1: dump_valid<=0, done<=1, go to DONE.
  - Else: k<=k+1, ra1<=2(k+1), ra2<=2(k+1)+1, dump_valid<=0, go to READ.
- DONE: done=1 for exactly this cycle; busy<=0, done<=0, go to IDLE.
- Writes to x31 never stall; x31 reads 0 from the regfile and is dumped as 0.
- Writes to an already-dumped or not-yet-read register have no effect on the dump.
- Latency with dump_ready held 1:
  - First valid beat in the 2nd cycle after the start edge.
  - 3 cycles per pair; done asserted 49 cycles after the start edge (NREG=32).
- start asserted while busy=1 or in DONE is ignored and is not queued.
- Reset mid-dump: dump_valid, busy and done are 0 after the reset edge. A subsequent start restarts from index 0.

Test Plan:
- Regfile at its initial contents (xi=i, x31=0), dump_ready=1, single start pulse → 32 beats with idx 0..31 and data=idx, except idx31 data=0. done pulses once, 49 cycles after start; busy then falls.
- dump_ready=0 for 5 cycles while beat idx=4 is valid → idx=4 and data=4 held stable for all 5 cycles; the next beat is idx=5, data=5; no beats lost or duplicated.
- we3=1, wa3=2, wd3=27 in the READ cycle of pair (2,3) → one extra READ cycle; beats are idx2=27, idx3=3.
- we3=1, wa3=31, wd3=52 during READ of pair (30,31) → no stall; beats are idx30=30, idx31=0.
- reset asserted while beat idx=10 is valid → next cycle dump_valid=0, busy=0, ra1=0. A new start produces beats beginning at idx0=0.
- start pulsed again at beat idx=6 → ignored; exactly 32 beats and one done pulse are produced.
